// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register-bank write-port arbiter.
// Arbiter state encoding and default sizing.
package reg_write_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_DEF        = 4;
    localparam int AW_DEF       = 5;
    localparam int DW_DEF       = 32;
    localparam int MAXBURST_DEF = 4;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Round-robin pick: one-hot choice of the first set request at or after ptr, with wrap.
// Purely combinational; vld_o is low when nothing is requesting.
import reg_write_arbiter_pkg::*;

module rr_pick #(
    parameter int N = N_DEF,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  pick_o,
    output logic          vld_o
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [2*N-1:0] dbl_req;
    logic [2*N-1:0] dbl_pick;
    logic [N-1:0]   rot_req;
    logic [N-1:0]   rot_pick;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        dbl_req  = {req_i, req_i} >> ptr_i;
        rot_req  = dbl_req[N-1:0];
        rot_pick = rot_req & ((~rot_req) + ONE);
        dbl_pick = {rot_pick, rot_pick} << ptr_i;
        pick_o   = dbl_pick[2*N-1:N];
        vld_o    = |req_i;
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register-bank write port among N requesters,
// with a registered one-hot grant held for at most MAXBURST writes.
import reg_write_arbiter_pkg::*;

module reg_write_arbiter #(
    parameter int N        = N_DEF,
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAXBURST = MAXBURST_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_i,
    input  logic [N*AW-1:0] wr_addr_i,
    input  logic [N*DW-1:0] wr_data_i,
    output logic [N-1:0]    gnt_o,
    output logic            rf_we_o,
    output logic [AW-1:0]   rf_addr_o,
    output logic [DW-1:0]   rf_data_o,
    output logic            busy_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAXBURST + 1);

    state_t        state_q;
    logic [N-1:0]  gnt_q;
    logic [PW-1:0] ptr_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;

    logic [PW-1:0] own;
    logic [PW-1:0] ptr_d;
    logic          owner_req;
    logic          wr_fire;
    logic          release_w;
    logic          arb_en;
    logic [N-1:0]  pick;
    logic          pick_vld;

    always_comb begin
        own = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i]) begin
                own = PW'(i);
            end
        end
    end

    assign owner_req = |(gnt_q & req_i);
    assign wr_fire   = (state_q == GRANT) && owner_req;
    assign release_w = (state_q == GRANT) &&
                       (!owner_req || (cnt_q == CW'(MAXBURST - 1)));
    assign arb_en    = (state_q == IDLE) || release_w;

    // On release the search starts just past the outgoing owner, so the
    // same edge can hand the port over (or back to the owner if it is alone).
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == GRANT) begin
            ptr_d = (own == PW'(N - 1)) ? '0 : own + PW'(1);
        end
    end

    rr_pick #(.N(N)) u_pick (
        .req_i  (req_i),
        .ptr_i  (ptr_d),
        .pick_o (pick),
        .vld_o  (pick_vld)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (arb_en) begin
            ptr_q <= ptr_d;
            cnt_q <= '0;
            if (pick_vld) begin
                state_q <= GRANT;
                gnt_q   <= pick;
                busy_q  <= 1'b1;
            end else begin
                state_q <= IDLE;
                gnt_q   <= '0;
                busy_q  <= 1'b0;
            end
        end else if (wr_fire) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // One-hot grant makes an AND-OR mux; all-zero grant yields zero outputs.
    always_comb begin
        rf_addr_o = '0;
        rf_data_o = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i]) begin
                rf_addr_o = rf_addr_o | wr_addr_i[i*AW +: AW];
                rf_data_o = rf_data_o | wr_data_i[i*DW +: DW];
            end
        end
    end

    assign rf_we_o = wr_fire && !rst_i;
    assign gnt_o   = gnt_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: per-cycle scoreboard against a
// behavioural model plus directed checks of grant order, handoff and reset.
module tb_reg_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int MB = 4;

    typedef struct {
        logic [N-1:0]  gnt;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          busy;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] wr_addr;
    logic [N*DW-1:0] wr_data;
    logic [N-1:0]    gnt;
    logic            rf_we;
    logic [AW-1:0]   rf_addr;
    logic [DW-1:0]   rf_data;
    logic            busy;

    int n_chk  = 0;
    int n_fail = 0;
    int m_own  = -1;
    int m_ptr  = 0;
    int m_cnt  = 0;
    exp_t sb[$];

    reg_write_arbiter #(.N(N), .AW(AW), .DW(DW), .MAXBURST(MB)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .gnt_o     (gnt),
        .rf_we_o   (rf_we),
        .rf_addr_o (rf_addr),
        .rf_data_o (rf_data),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, compare this cycle's outputs, then advance the model
    // to what the coming rising edge should produce.
    task automatic cycle(input logic r, input logic [N-1:0] rq);
        exp_t e;
        exp_t o;
        bit   arb;
        @(negedge clk);
        rst = r;
        req = rq;
        #1;
        e.gnt  = (m_own < 0) ? '0 : N'(1 << m_own);
        e.we   = (m_own >= 0) && rq[m_own] && !r;
        e.addr = (m_own < 0) ? '0 : wr_addr[m_own*AW +: AW];
        e.data = (m_own < 0) ? '0 : wr_data[m_own*DW +: DW];
        e.busy = (m_own >= 0);
        sb.push_back(e);
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            o = sb.pop_front();
            chk("gnt",  64'(gnt),     64'(o.gnt));
            chk("we",   64'(rf_we),   64'(o.we));
            chk("addr", 64'(rf_addr), 64'(o.addr));
            chk("data", 64'(rf_data), 64'(o.data));
            chk("busy", 64'(busy),    64'(o.busy));
        end
        if (r) begin
            m_own = -1;
            m_ptr = 0;
            m_cnt = 0;
        end else begin
            arb = (m_own < 0);
            if (m_own >= 0) begin
                if (rq[m_own]) begin
                    m_cnt++;
                    if (m_cnt == MB) arb = 1;
                end else begin
                    arb = 1;
                end
                if (arb) m_ptr = (m_own + 1) % N;
            end
            if (arb) begin
                m_own = -1;
                m_cnt = 0;
                for (int k = 0; k < N; k++) begin
                    if (m_own < 0 && rq[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
                end
            end
        end
    endtask

    initial begin
        int nw;
        logic [N-1:0] eg;
        rst     = 1'b1;
        req     = 4'b1111;
        wr_addr = {5'd3, 5'd2, 5'd1, 5'd0};
        wr_data = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};

        // reset with everyone requesting, then first grant goes to 0
        cycle(1'b1, 4'b1111);
        chk("t1_gnt_rst", 64'(gnt), 64'd0);
        chk("t1_we_rst", 64'(rf_we), 64'd0);
        cycle(1'b1, 4'b1111);
        cycle(1'b0, 4'b1111);
        chk("t1_gnt_idle", 64'(gnt), 64'd0);
        cycle(1'b0, 4'b1111);
        chk("t1_gnt_first", 64'(gnt), 64'b0001);

        // single requester: continuous writes across re-grants
        cycle(1'b1, 4'b0000);
        cycle(1'b0, 4'b0100);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 4'b0100);
            chk("t2_gnt", 64'(gnt), 64'b0100);
            chk("t2_we", 64'(rf_we), 64'd1);
        end

        // all requesting: strict rotation, MB writes each
        cycle(1'b1, 4'b0000);
        cycle(1'b0, 4'b1111);
        nw = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 4'b1111);
            eg = 4'b0001 << ((k / MB) % N);
            chk("t3_gnt", 64'(gnt), 64'(eg));
            if (k < N * MB && rf_we) nw++;
        end
        chk("t3_writes", 64'(nw), 64'(N * MB));

        // owner 1 drops after two writes, requester 3 takes over
        cycle(1'b1, 4'b0000);
        cycle(1'b0, 4'b0010);
        cycle(1'b0, 4'b1010);
        chk("t4_gnt1", 64'(gnt), 64'b0010);
        cycle(1'b0, 4'b1010);
        cycle(1'b0, 4'b1000);
        chk("t4_no_we", 64'(rf_we), 64'd0);
        cycle(1'b0, 4'b1000);
        chk("t4_gnt3", 64'(gnt), 64'b1000);
        chk("t4_ptr", 64'(dut.ptr_q), 64'd2);

        // data path from requester 2
        cycle(1'b1, 4'b0000);
        wr_addr[2*AW +: AW] = 5'd7;
        wr_data[2*DW +: DW] = 32'hDEAD_BEEF;
        cycle(1'b0, 4'b0100);
        cycle(1'b0, 4'b0100);
        chk("t5_gnt", 64'(gnt), 64'b0100);
        chk("t5_we", 64'(rf_we), 64'd1);
        chk("t5_addr", 64'(rf_addr), 64'd7);
        chk("t5_data", 64'(rf_data), 64'hDEAD_BEEF);

        // reset in the second cycle of a burst
        cycle(1'b1, 4'b0000);
        cycle(1'b0, 4'b0100);
        cycle(1'b0, 4'b0100);
        cycle(1'b1, 4'b0100);
        chk("t6_we_rst", 64'(rf_we), 64'd0);
        cycle(1'b0, 4'b1111);
        chk("t6_gnt_zero", 64'(gnt), 64'd0);
        chk("t6_ptr_zero", 64'(dut.ptr_q), 64'd0);
        cycle(1'b0, 4'b1111);
        chk("t6_gnt0", 64'(gnt), 64'b0001);

        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            wr_addr = N*AW'($urandom());
            wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            cycle(($urandom_range(0, 63) == 0), N'($urandom()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
